// File: rtl/game_state_ctrl_n.sv
// Game-state controller: merges ball and player hazards into a registered
// stop/freeze FSM that owns lives, game-over and win decisions.
module game_state_ctrl_n #(
    parameter int NUM_BALLS     = 4,
    parameter int LIVES         = 3,
    parameter int LIVES_W       = 2,
    parameter int FREEZE_FRAMES = 60,
    parameter int SCORE_W       = 7,
    parameter int WIN_SCORE     = 75,
    parameter int SRC_W         = 3
) (
    input  logic                 clk_65M,
    input  logic                 clear,
    input  logic                 frame_tick,
    input  logic                 game_start,
    input  logic                 pause,
    input  logic [NUM_BALLS-1:0] ball_en,
    input  logic [NUM_BALLS-1:0] ball_hit,
    input  logic                 player_hit,
    input  logic                 in_shaded,
    input  logic [SCORE_W-1:0]   score,
    output logic                 istop,
    output logic                 game_stop,
    output logic [LIVES_W-1:0]   lives,
    output logic [SRC_W-1:0]     hit_src,
    output logic                 game_end,
    output logic                 game_win,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_FREEZE = 3'd2,
        S_OVER   = 3'd3,
        S_WIN    = 3'd4
    } state_t;

    state_t               r_state, w_next;
    logic [LIVES_W-1:0]   r_lives, w_lives;
    logic [7:0]           r_cnt, w_cnt;
    logic [SRC_W-1:0]     r_src, w_src;
    logic                 r_stop_pulse, w_stop_pulse;
    logic                 r_istop;
    logic [NUM_BALLS-1:0] w_masked;
    logic                 w_hazard;
    logic                 w_win;

    // Lowest enabled ball index wins; an all-zero mask means the player hit.
    function automatic logic [SRC_W-1:0] f_src(input logic [NUM_BALLS-1:0] m);
        f_src = SRC_W'(NUM_BALLS);
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (m[i]) f_src = SRC_W'(i);
        end
    endfunction

    assign w_masked = ball_hit & ball_en;
    assign w_hazard = ((|w_masked) | player_hit) & ~in_shaded & ~pause;
    assign w_win    = (score >= SCORE_W'(WIN_SCORE));

    always_comb begin
        w_next       = r_state;
        w_lives      = r_lives;
        w_cnt        = r_cnt;
        w_src        = r_src;
        w_stop_pulse = 1'b0;
        case (r_state)
            S_IDLE, S_OVER, S_WIN: begin
                if (game_start) begin
                    w_next  = S_PLAY;
                    w_lives = LIVES_W'(LIVES);
                end
            end
            S_PLAY: begin
                // A paused game holds PLAY untouched, including the win check.
                if (!pause) begin
                    if (w_win) begin
                        w_next = S_WIN;
                    end else if (w_hazard) begin
                        w_stop_pulse = 1'b1;
                        w_src        = f_src(w_masked);
                        if (r_lives <= LIVES_W'(1)) begin
                            w_lives = '0;
                            w_next  = S_OVER;
                        end else begin
                            w_lives = r_lives - LIVES_W'(1);
                            w_next  = S_FREEZE;
                            w_cnt   = '0;
                        end
                    end
                end
            end
            S_FREEZE: begin
                if (frame_tick && !pause) begin
                    if (r_cnt + 8'd1 == 8'(FREEZE_FRAMES)) begin
                        w_next = S_PLAY;
                        w_cnt  = '0;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_65M) begin
        if (clear) begin
            r_state      <= S_IDLE;
            r_lives      <= LIVES_W'(LIVES);
            r_cnt        <= '0;
            r_src        <= '0;
            r_stop_pulse <= 1'b0;
            r_istop      <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_lives      <= w_lives;
            r_cnt        <= w_cnt;
            r_src        <= w_src;
            r_stop_pulse <= w_stop_pulse;
            r_istop      <= (w_next != S_PLAY);
        end
    end

    assign istop     = r_istop;
    assign game_stop = r_stop_pulse;
    assign lives     = r_lives;
    assign hit_src   = r_src;
    assign game_end  = (r_state == S_OVER);
    assign game_win  = (r_state == S_WIN);
    assign state     = r_state;

endmodule

// File: doc/game_state_ctrl_n.md
Name: game_state_ctrl_n

Overview:
- Parametrised game-state controller that collects hazard hits from NUM_BALLS ball engines and the player trail, and owns the stop/freeze, life counting, game-over and win decisions.
- Replaces the ad-hoc combinational istop OR-tree and the standalone life counter with a registered FSM.
- Sits between the ball/player engines and the game renderer, in the clk_65M domain.

Parameters:
- NUM_BALLS, 4, number of ball hazard channels (1..16).
- LIVES, 3, lives loaded at game start (1..15).
- LIVES_W, 2, width of the lives output; must hold LIVES.
- FREEZE_FRAMES, 60, number of frame_tick pulses held in FREEZE after a non-fatal hit (1..255).
- SCORE_W, 7, width of the score input.
- WIN_SCORE, 75, score at or above which the game is won.
- SRC_W, 3, width of hit_src; must hold NUM_BALLS.

Ports:
- clk_65M, input, 1, system pixel clock; the only clock.
- clear, input, 1, synchronous active-high reset.
- frame_tick, input, 1, one-cycle pulse per frame (start of vertical blank).
- game_start, input, 1, debounced one-cycle start pulse.
- pause, input, 1, level; freezes play.
- ball_en, input, NUM_BALLS, per-channel enable mask.
- ball_hit, input, NUM_BALLS, per-ball collision flags (level).
- player_hit, input, 1, player self-collision or trail-cut flag.
- in_shaded, input, 1, player inside a captured region; masks all hazards.
- score, input, SCORE_W, current captured-area score.
- istop, output, 1, registered stop to all motion engines.
- game_stop, output, 1, one-cycle pulse per life lost.
- lives, output, LIVES_W, remaining lives.
- hit_src, output, SRC_W, source of the last hit: index of the lowest-numbered ball, or NUM_BALLS for the player.
- game_end, output, 1, high in OVER.
- game_win, output, 1, high in WIN.
- state, output, 3, FSM state for debug: IDLE=0, PLAY=1, FREEZE=2, OVER=3, WIN=4.

Behaviour:
- Reset (clear=1 at a clk_65M edge) takes priority over every other input.
  - state=IDLE, lives=LIVES, istop=1, game_stop=0, hit_src=0, game_end=0, game_win=0, freeze counter=0.
  - A reset mid-FREEZE or mid-OVER aborts immediately.
- hazard = ((|(ball_hit & ball_en)) | player_hit) & ~in_shaded & ~pause. The term is combinational; every response to it is registered.
- IDLE:
  - istop=1.
  - game_start -> PLAY; lives reloaded to LIVES; istop=0 on the next cycle.
- PLAY (istop=0), evaluated in this priority order:
  - score >= WIN_SCORE -> WIN. Win beats a hazard in the same cycle.
  - Otherwise, on hazard:
    - game_stop=1 for exactly one cycle; hit_src latched; istop=1 from the next cycle.
    - lives decrements by 1, saturating at 0.
    - If lives was 1 -> OVER; else -> FREEZE with counter cleared.
  - Latency: ball_hit at edge N gives istop=1, game_stop=1 and the updated lives at edge N+1.
  - pause=1 holds PLAY with no state change.
  - game_start is ignored.
- FREEZE:
  - istop=1; hazards ignored.
  - Counter increments on frame_tick only when pause=0.
  - When the counter reaches FREEZE_FRAMES on a frame_tick -> PLAY; istop=0 on the next cycle.
  - game_start is ignored.
- OVER:
  - istop=1, game_end=1, lives=0.
  - game_start -> PLAY; lives=LIVES; game_end=0; hit_src is kept.
- WIN:
  - istop=1, game_win=1.
  - game_start -> PLAY; lives=LIVES; game_win=0.
- hit_src:
  - Changes only on a counted hazard.
  - If several balls hit in the same cycle, the lowest index wins.
  - If balls and player hit together, the ball index wins.
- Masked channels (ball_en=0) never cause a hit, even when asserted.
- game_stop never asserts outside PLAY.
- At most one life is lost per entry into PLAY: hazard held high across the PLAY->FREEZE edge loses one life only.
- Unused state encodings -> IDLE on the next cycle.

Test Plan:
- clear 3 cycles, then game_start pulse -> state 0 then 1; lives=3; istop=0 one cycle after start.
- In PLAY, ball_hit=4'b0110 for 5 cycles with ball_en=4'hF -> a single game_stop pulse, lives=2, hit_src=1, state=2; 60 frame_ticks later state=1, istop=0.
- Three successive hits, each after its freeze completes -> lives 2, 1, 0; third hit goes directly to state=3 with game_end=1; a further game_start -> lives=3, state=1, game_end=0.
- ball_hit=4'b1000 with ball_en=4'b0111, then player_hit=1 with in_shaded=1 -> no game_stop and lives unchanged; player_hit with in_shaded=0 -> hit_src=4.
- score steps to 75 in the same cycle as ball_hit[0] -> state=4, game_win=1, lives unchanged, no game_stop.
- Mid-FREEZE: pause=1 through 100 frame_ticks -> counter holds; then clear=1 -> state=0, lives=3, istop=1 on the next edge.
